// File: rtl/axi_rd_sched.sv
// AXI read-side scheduler: arbitrates fetch and load requests onto one AR
// channel, caps outstanding reads per ID, routes R beats, blocks RAW loads.
module axi_rd_sched #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned WR_DEPTH  = 4,
  parameter bit          DATA_PRIO = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  input  logic [31:0] inst_req_addr,
  input  logic [2:0]  inst_req_size,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_req_addr,
  input  logic [2:0]  data_req_size,
  output logic        inst_resp_valid,
  input  logic        inst_resp_ready,
  output logic [31:0] inst_resp_data,
  output logic        data_resp_valid,
  input  logic        data_resp_ready,
  output logic [31:0] data_resp_data,
  input  logic        wr_issue,
  input  logic [31:0] wr_issue_addr,
  output logic        wr_issue_ready,
  input  logic        wr_done,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err_unk_id
);

  localparam int unsigned PW = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
  localparam logic [2:0] MAXC = 3'(MAX_OUTST);
  localparam logic [PW:0] FULLC = (PW+1)'(WR_DEPTH);
  localparam logic [PW-1:0] LASTP = PW'(WR_DEPTH - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        rr_q, rr_d;
  logic [2:0]  cnt0_q, cnt0_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic        err_q, err_d;

  logic [29:0]         wt_addr_q [WR_DEPTH];
  logic [WR_DEPTH-1:0] wt_vld_q, wt_vld_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [PW:0]         wcnt_q, wcnt_d;

  logic hazard;
  logic inst_elig;
  logic data_elig;
  logic gnt_inst;
  logic gnt_data;
  logic full;
  logic push;
  logic pop;
  logic inc0, dec0;
  logic inc1, dec1;
  logic r_hs;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(WR_DEPTH); i++) begin
      if (wt_vld_q[i] && (wt_addr_q[i] == data_req_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  assign inst_elig = inst_req_valid && (cnt0_q < MAXC);
  assign data_elig = data_req_valid && (cnt1_q < MAXC) && !hazard;

  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    rr_d     = rr_q;
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    case (state_q)
      IDLE: begin
        // rr_q set means data is owed the next contended grant
        if (data_elig && (!inst_elig || DATA_PRIO || rr_q)) begin
          gnt_data = 1'b1;
        end else if (inst_elig) begin
          gnt_inst = 1'b1;
        end
        if (gnt_data) begin
          arid_d   = 4'd1;
          araddr_d = data_req_addr;
          arsize_d = data_req_size;
          rr_d     = 1'b0;
          state_d  = ISSUE;
        end else if (gnt_inst) begin
          arid_d   = 4'd0;
          araddr_d = inst_req_addr;
          arsize_d = inst_req_size;
          rr_d     = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (arready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_req_ready = gnt_inst;
  assign data_req_ready = gnt_data;
  assign arvalid        = (state_q == ISSUE);
  assign arid           = arid_q;
  assign araddr         = araddr_q;
  assign arsize         = arsize_q;

  always_comb begin
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    rready          = 1'b1;
    if (rid == 4'd0) begin
      inst_resp_valid = rvalid;
      rready          = inst_resp_ready;
    end else if (rid == 4'd1) begin
      data_resp_valid = rvalid;
      rready          = data_resp_ready;
    end
  end

  assign inst_resp_data = rdata;
  assign data_resp_data = rdata;
  assign err_unk_id     = err_q;

  assign r_hs = rvalid && rready && rlast;
  assign inc0 = gnt_inst;
  assign inc1 = gnt_data;
  // Guard against beats of reads abandoned by a reset
  assign dec0 = r_hs && (rid == 4'd0) && (cnt0_q != 3'd0);
  assign dec1 = r_hs && (rid == 4'd1) && (cnt1_q != 3'd0);

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    case ({inc0, dec0})
      2'b10:   cnt0_d = cnt0_q + 3'd1;
      2'b01:   cnt0_d = cnt0_q - 3'd1;
      default: cnt0_d = cnt0_q;
    endcase
    case ({inc1, dec1})
      2'b10:   cnt1_d = cnt1_q + 3'd1;
      2'b01:   cnt1_d = cnt1_q - 3'd1;
      default: cnt1_d = cnt1_q;
    endcase
    if (rvalid && (rid > 4'd1)) begin
      err_d = 1'b1;
    end
  end

  assign full           = (wcnt_q == FULLC);
  assign wr_issue_ready = !full;
  assign pop            = wr_done && (wcnt_q != '0);
  // A simultaneous pop frees the slot, so a push is taken even when full
  assign push           = wr_issue && (!full || pop);

  always_comb begin
    wt_vld_d = wt_vld_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wcnt_d   = wcnt_q;
    if (pop) begin
      wt_vld_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == LASTP) ? '0 : rptr_q + 1'b1;
    end
    if (push) begin
      wt_vld_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == LASTP) ? '0 : wptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   wcnt_d = wcnt_q + 1'b1;
      2'b01:   wcnt_d = wcnt_q - 1'b1;
      default: wcnt_d = wcnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      arid_q   <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      rr_q     <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      err_q    <= 1'b0;
      wt_vld_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      rr_q     <= rr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      err_q    <= err_d;
      wt_vld_q <= wt_vld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      wt_addr_q[wptr_q] <= wr_issue_addr[31:2];
    end
  end

endmodule

// File: tb/tb_axi_rd_sched.sv
// Directed bench for axi_rd_sched: a priority instance and a
// round-robin instance, checked with immediate assertions.
module tb_axi_rd_sched;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_req_addr;
  logic [2:0]  inst_req_size;
  logic        data_req_valid, data_req_ready;
  logic [31:0] data_req_addr;
  logic [2:0]  data_req_size;
  logic        inst_resp_valid, inst_resp_ready;
  logic [31:0] inst_resp_data;
  logic        data_resp_valid, data_resp_ready;
  logic [31:0] data_resp_data;
  logic        wr_issue, wr_issue_ready, wr_done;
  logic [31:0] wr_issue_addr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic        err_unk_id;

  logic        rr_iv, rr_ir, rr_dv, rr_dr;
  logic        rr_irv, rr_drv, rr_wir, rr_arvalid, rr_arready;
  logic        rr_rready, rr_err, rr_zero;
  logic [31:0] rr_ird, rr_drd, rr_araddr;
  logic [3:0]  rr_arid;
  logic [2:0]  rr_arsize;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi_rd_sched #(.MAX_OUTST(2), .WR_DEPTH(4), .DATA_PRIO(1'b1)) u_dut (
    .aclk(aclk), .areset(areset),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_req_addr(inst_req_addr), .inst_req_size(inst_req_size),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_addr(data_req_addr), .data_req_size(data_req_size),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .inst_resp_data(inst_resp_data),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
    .data_resp_data(data_resp_data),
    .wr_issue(wr_issue), .wr_issue_addr(wr_issue_addr),
    .wr_issue_ready(wr_issue_ready), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .err_unk_id(err_unk_id)
  );

  axi_rd_sched #(.MAX_OUTST(2), .WR_DEPTH(4), .DATA_PRIO(1'b0)) u_rr (
    .aclk(aclk), .areset(areset),
    .inst_req_valid(rr_iv), .inst_req_ready(rr_ir),
    .inst_req_addr(inst_req_addr), .inst_req_size(inst_req_size),
    .data_req_valid(rr_dv), .data_req_ready(rr_dr),
    .data_req_addr(data_req_addr), .data_req_size(data_req_size),
    .inst_resp_valid(rr_irv), .inst_resp_ready(inst_resp_ready),
    .inst_resp_data(rr_ird),
    .data_resp_valid(rr_drv), .data_resp_ready(data_resp_ready),
    .data_resp_data(rr_drd),
    .wr_issue(rr_zero), .wr_issue_addr(wr_issue_addr),
    .wr_issue_ready(rr_wir), .wr_done(rr_zero),
    .arid(rr_arid), .araddr(rr_araddr), .arsize(rr_arsize),
    .arvalid(rr_arvalid), .arready(rr_arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rr_zero),
    .rready(rr_rready), .err_unk_id(rr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1;
    inst_req_valid = 0; inst_req_addr = 0; inst_req_size = 3'd2;
    data_req_valid = 0; data_req_addr = 0; data_req_size = 3'd2;
    inst_resp_ready = 0; data_resp_ready = 0;
    wr_issue = 0; wr_issue_addr = 0; wr_done = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    rr_iv = 0; rr_dv = 0; rr_arready = 0; rr_zero = 0;
    step();
    step();
    areset = 1'b0;
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_err", 32'(err_unk_id), 32'd0);
    chk("rst_wready", 32'(wr_issue_ready), 32'd1);
    chk("rst_iready", 32'(inst_req_ready), 32'd0);

    // round-robin instance alternates inst/data/inst
    inst_req_addr = 32'h1000; data_req_addr = 32'h2000;
    rr_iv = 1; rr_dv = 1; rr_arready = 1;
    #1;
    chk("rr_g0_inst", 32'(rr_ir), 32'd1);
    chk("rr_g0_data", 32'(rr_dr), 32'd0);
    step();
    chk("rr_ar0_valid", 32'(rr_arvalid), 32'd1);
    chk("rr_ar0_id", 32'(rr_arid), 32'd0);
    step();
    chk("rr_g1_data", 32'(rr_dr), 32'd1);
    chk("rr_g1_inst", 32'(rr_ir), 32'd0);
    step();
    chk("rr_ar1_id", 32'(rr_arid), 32'd1);
    chk("rr_ar1_addr", rr_araddr, 32'h2000);
    step();
    chk("rr_g2_inst", 32'(rr_ir), 32'd1);
    step();
    chk("rr_ar2_id", 32'(rr_arid), 32'd0);
    rr_iv = 0; rr_dv = 0;
    step();

    // single fetch
    inst_req_valid = 1; inst_req_addr = 32'h1C00_0000; arready = 1;
    #1;
    chk("f_iready", 32'(inst_req_ready), 32'd1);
    chk("f_dready", 32'(data_req_ready), 32'd0);
    step();
    inst_req_valid = 0;
    #1;
    chk("f_arvalid", 32'(arvalid), 32'd1);
    chk("f_arid", 32'(arid), 32'd0);
    chk("f_araddr", araddr, 32'h1C00_0000);
    chk("f_arsize", 32'(arsize), 32'd2);
    chk("f_cnt0_1", 32'(u_dut.cnt0_q), 32'd1);
    chk("f_iready_issue", 32'(inst_req_ready), 32'd0);
    step();
    chk("f_arvalid_off", 32'(arvalid), 32'd0);
    rvalid = 1; rid = 4'd0; rdata = 32'hDEAD_BEEF; rlast = 1;
    inst_resp_ready = 1;
    #1;
    chk("f_rvalid", 32'(inst_resp_valid), 32'd1);
    chk("f_rdata", inst_resp_data, 32'hDEAD_BEEF);
    chk("f_dvalid_other", 32'(data_resp_valid), 32'd0);
    chk("f_rready", 32'(rready), 32'd1);
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("f_cnt0_0", 32'(u_dut.cnt0_q), 32'd0);

    // contention with data priority
    inst_req_valid = 1; inst_req_addr = 32'h1000;
    data_req_valid = 1; data_req_addr = 32'h2000;
    #1;
    chk("c_dready", 32'(data_req_ready), 32'd1);
    chk("c_iready", 32'(inst_req_ready), 32'd0);
    step();
    data_req_valid = 0;
    #1;
    chk("c_arid1", 32'(arid), 32'd1);
    chk("c_araddr1", araddr, 32'h2000);
    chk("c_iready_issue", 32'(inst_req_ready), 32'd0);
    step();
    chk("c_iready_next", 32'(inst_req_ready), 32'd1);
    step();
    inst_req_valid = 0;
    #1;
    chk("c_arid0", 32'(arid), 32'd0);
    chk("c_araddr0", araddr, 32'h1000);
    step();
    rvalid = 1; rid = 4'd1; rlast = 1; rdata = 32'h1111_2222;
    data_resp_ready = 0;
    #1;
    chk("r_bp_rready", 32'(rready), 32'd0);
    chk("r_d_valid", 32'(data_resp_valid), 32'd1);
    chk("r_i_valid_other", 32'(inst_resp_valid), 32'd0);
    step();
    chk("r_bp_cnt1", 32'(u_dut.cnt1_q), 32'd1);
    data_resp_ready = 1;
    #1;
    chk("r_d_rready", 32'(rready), 32'd1);
    chk("r_d_data", data_resp_data, 32'h1111_2222);
    step();
    chk("r_cnt1_0", 32'(u_dut.cnt1_q), 32'd0);
    rid = 4'd0; rlast = 0; rdata = 32'h3;
    step();
    chk("r_nolast_cnt0", 32'(u_dut.cnt0_q), 32'd1);
    rlast = 1;
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("r_last_cnt0", 32'(u_dut.cnt0_q), 32'd0);

    // outstanding cap
    inst_req_valid = 1; inst_req_addr = 32'h4000;
    #1;
    chk("cap_acc1", 32'(inst_req_ready), 32'd1);
    step();
    step();
    chk("cap_acc2", 32'(inst_req_ready), 32'd1);
    step();
    step();
    chk("cap_block", 32'(inst_req_ready), 32'd0);
    chk("cap_cnt0_2", 32'(u_dut.cnt0_q), 32'd2);
    step();
    chk("cap_block2", 32'(inst_req_ready), 32'd0);
    rvalid = 1; rid = 4'd0; rlast = 1;
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("cap_release", 32'(inst_req_ready), 32'd1);
    step();
    inst_req_valid = 0;
    step();
    rvalid = 1; rid = 4'd0; rlast = 1;
    step();
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("cap_drain_cnt0", 32'(u_dut.cnt0_q), 32'd0);

    // read-after-write hazard
    wr_issue = 1; wr_issue_addr = 32'h100;
    #1;
    chk("raw_wready", 32'(wr_issue_ready), 32'd1);
    step();
    wr_issue = 0;
    data_req_valid = 1; data_req_addr = 32'h102;
    #1;
    chk("raw_block", 32'(data_req_ready), 32'd0);
    data_req_addr = 32'h200;
    #1;
    chk("raw_other_ok", 32'(data_req_ready), 32'd1);
    step();
    data_req_addr = 32'h102;
    #1;
    chk("raw_other_addr", araddr, 32'h200);
    chk("raw_other_id", 32'(arid), 32'd1);
    step();
    chk("raw_block_idle", 32'(data_req_ready), 32'd0);
    wr_done = 1;
    #1;
    chk("raw_block_pop", 32'(data_req_ready), 32'd0);
    step();
    wr_done = 0;
    #1;
    chk("raw_release", 32'(data_req_ready), 32'd1);
    step();
    data_req_valid = 0;
    #1;
    chk("raw_addr", araddr, 32'h102);
    step();
    rvalid = 1; rid = 4'd1; rlast = 1; data_resp_ready = 1;
    step();
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("raw_cnt1_0", 32'(u_dut.cnt1_q), 32'd0);

    // write table full
    for (int i = 1; i <= 4; i++) begin
      wr_issue = 1; wr_issue_addr = 32'(i) << 12;
      step();
    end
    wr_issue = 0;
    #1;
    chk("full_wready", 32'(wr_issue_ready), 32'd0);
    data_req_valid = 1; data_req_addr = 32'h1000;
    inst_req_valid = 1; inst_req_addr = 32'h1000;
    #1;
    chk("full_hz_1000", 32'(data_req_ready), 32'd0);
    chk("full_fetch_nohz", 32'(inst_req_ready), 32'd1);
    data_req_valid = 0; inst_req_valid = 0;
    wr_issue = 1; wr_issue_addr = 32'h5000; wr_done = 1;
    #1;
    chk("full_swap_wready", 32'(wr_issue_ready), 32'd0);
    step();
    wr_issue = 0; wr_done = 0;
    #1;
    chk("swap_still_full", 32'(wr_issue_ready), 32'd0);
    data_req_valid = 1; data_req_addr = 32'h1000;
    #1;
    chk("swap_1000_gone", 32'(data_req_ready), 32'd1);
    data_req_addr = 32'h5000;
    #1;
    chk("swap_5000_in", 32'(data_req_ready), 32'd0);
    data_req_addr = 32'h2000;
    #1;
    chk("swap_2000_in", 32'(data_req_ready), 32'd0);
    data_req_valid = 0;
    wr_done = 1;
    step();
    wr_done = 0;
    #1;
    chk("pop_wready", 32'(wr_issue_ready), 32'd1);
    data_req_valid = 1; data_req_addr = 32'h2000;
    #1;
    chk("pop_2000_gone", 32'(data_req_ready), 32'd1);
    data_req_addr = 32'h5000;
    #1;
    chk("pop_5000_kept", 32'(data_req_ready), 32'd0);
    data_req_valid = 0;

    // reset during ISSUE, then an unknown rid
    arready = 0;
    inst_req_valid = 1; inst_req_addr = 32'h3000;
    #1;
    chk("mr_accept", 32'(inst_req_ready), 32'd1);
    step();
    inst_req_valid = 0;
    step();
    chk("mr_arvalid_held", 32'(arvalid), 32'd1);
    chk("mr_araddr_held", araddr, 32'h3000);
    chk("mr_cnt0", 32'(u_dut.cnt0_q), 32'd1);
    areset = 1;
    step();
    areset = 0;
    #1;
    chk("mr_arvalid", 32'(arvalid), 32'd0);
    chk("mr_araddr", araddr, 32'd0);
    chk("mr_cnt0_0", 32'(u_dut.cnt0_q), 32'd0);
    chk("mr_cnt1_0", 32'(u_dut.cnt1_q), 32'd0);
    chk("mr_wready", 32'(wr_issue_ready), 32'd1);
    data_req_valid = 1; data_req_addr = 32'h5000;
    #1;
    chk("mr_table_empty", 32'(data_req_ready), 32'd1);
    data_req_valid = 0;
    inst_resp_ready = 0; data_resp_ready = 0;
    rvalid = 1; rid = 4'd5; rlast = 1;
    #1;
    chk("unk_rready", 32'(rready), 32'd1);
    chk("unk_ivalid", 32'(inst_resp_valid), 32'd0);
    chk("unk_dvalid", 32'(data_resp_valid), 32'd0);
    chk("unk_err_pre", 32'(err_unk_id), 32'd0);
    step();
    rvalid = 0; rlast = 0; rid = 4'd0;
    #1;
    chk("unk_err_set", 32'(err_unk_id), 32'd1);
    step();
    chk("unk_err_sticky", 32'(err_unk_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
